tft_bus_arbiter: RTL and testbench

TFT_BUS_ARBITER -- requirements
Module: tft_bus_arbiter

---
 rtl/tft_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_tft_bus_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tft_bus_arbiter.sv
// Arbitrates several TFT SPI clients onto one tft_spi transmitter.
// A boot client (init sequencer) runs alone after reset; the rest are then arbitrated.
module tft_bus_arbiter #(
  parameter int N_CH    = 4,
  parameter int DW      = 8,
  parameter int RR      = 1,
  parameter int BOOT_CH = 0,
  parameter int BOOT_TO = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    req,
  input  logic [N_CH*DW-1:0] ch_data,
  input  logic [N_CH-1:0]    ch_dc,
  input  logic [N_CH-1:0]    ch_transmit,
  input  logic               spi_busy,
  output logic [DW-1:0]      spi_data,
  output logic               spi_dc,
  output logic               spi_transmit,
  output logic [N_CH-1:0]    enable,
  output logic [N_CH-1:0]    grant,
  output logic               boot_done,
  output logic [7:0]         drop_cnt
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW = $clog2(BOOT_TO + 1);
  localparam logic [N_CH-1:0] BOOT_MASK = N_CH'(1) << BOOT_CH;

  typedef enum logic [1:0] {BOOT_WAIT, BOOT_RUN, IDLE, OWNED} state_t;

  state_t          state_reg, state_next;
  logic [N_CH-1:0] grant_reg, grant_next;
  logic [N_CH-1:0] enable_reg, enable_next;
  logic            boot_done_reg, boot_done_next;
  logic [7:0]      drop_cnt_reg, drop_cnt_next;
  logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [TW-1:0]   timer_reg, timer_next;

  logic [N_CH-1:0] cand;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   owner_idx;
  logic            owner_req;
  logic            blocked;
  int              rr_int;
  int              pos;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= BOOT_WAIT;
      grant_reg     <= '0;
      enable_reg    <= BOOT_MASK;
      boot_done_reg <= 1'b0;
      drop_cnt_reg  <= '0;
      rr_ptr_reg    <= '0;
      timer_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      enable_reg    <= enable_next;
      boot_done_reg <= boot_done_next;
      drop_cnt_reg  <= drop_cnt_next;
      rr_ptr_reg    <= rr_ptr_next;
      timer_reg     <= timer_next;
    end
  end

  // Winner search starts at rr_ptr (round-robin) or at 0 (fixed priority), wrapping upward.
  always_comb begin
    cand      = req & enable_reg;
    win_found = 1'b0;
    win_idx   = '0;
    rr_int    = int'(rr_ptr_reg);
    pos       = 0;
    for (int k = 0; k < N_CH; k++) begin
      pos = (RR != 0) ? rr_int + k : k;
      if (pos >= N_CH) pos = pos - N_CH;
      for (int i = 0; i < N_CH; i++) begin
        if (!win_found && pos == i && cand[i]) begin
          win_found = 1'b1;
          win_idx   = IW'(i);
        end
      end
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_reg[i]) owner_idx = IW'(i);
    end
    owner_req = |(req & grant_reg);
    blocked   = |(ch_transmit & ~grant_reg);
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    enable_next    = enable_reg;
    boot_done_next = boot_done_reg;
    rr_ptr_next    = rr_ptr_reg;
    timer_next     = timer_reg;
    drop_cnt_next  = (blocked && drop_cnt_reg != 8'hFF) ? drop_cnt_reg + 8'd1 : drop_cnt_reg;
    case (state_reg)
      BOOT_WAIT: begin
        if (req[BOOT_CH]) begin
          state_next = BOOT_RUN;
          grant_next = BOOT_MASK;
        end else if (timer_reg == TW'(BOOT_TO - 1)) begin
          state_next     = IDLE;
          boot_done_next = 1'b1;
          enable_next    = ~BOOT_MASK;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      BOOT_RUN: begin
        if (!req[BOOT_CH] && !spi_busy) begin
          state_next     = IDLE;
          grant_next     = '0;
          boot_done_next = 1'b1;
          enable_next    = ~BOOT_MASK;
        end
      end
      IDLE: begin
        if (win_found) begin
          state_next = OWNED;
          grant_next = N_CH'(1) << win_idx;
        end
      end
      OWNED: begin
        if (!owner_req && !spi_busy) begin
          state_next  = IDLE;
          grant_next  = '0;
          rr_ptr_next = (owner_idx == IW'(N_CH - 1)) ? '0 : owner_idx + 1'b1;
        end
      end
      default: state_next = BOOT_WAIT;
    endcase
  end

  // Only the granted channel's lane survives the mask, so others never reach tft_spi.
  logic [DW-1:0] lane_data [N_CH];
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
      assign lane_data[gi] = grant_reg[gi] ? ch_data[gi*DW +: DW] : '0;
    end
  endgenerate

  always_comb begin
    spi_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      spi_data = spi_data | lane_data[i];
    end
    spi_dc       = |(grant_reg & ch_dc);
    spi_transmit = |(grant_reg & ch_transmit);
  end

  assign grant     = grant_reg;
  assign enable    = enable_reg;
  assign boot_done = boot_done_reg;
  assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_tft_bus_arbiter.sv
// Bench for tft_bus_arbiter: a round-robin/short-timeout instance and a fixed-priority instance.
module tb_tft_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst          [2];
  logic [3:0]  req          [2];
  logic [31:0] ch_data      [2];
  logic [3:0]  ch_dc        [2];
  logic [3:0]  ch_transmit  [2];
  logic        spi_busy     [2];
  logic [7:0]  spi_data     [2];
  logic        spi_dc       [2];
  logic        spi_transmit [2];
  logic [3:0]  enable       [2];
  logic [3:0]  grant        [2];
  logic        boot_done    [2];
  logic [7:0]  drop_cnt     [2];

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q  [$];
  logic [7:0] drop_q [$];

  typedef struct {
    logic [3:0] tx;
    logic       exp_st;
    logic [7:0] exp_drop;
  } vec_t;
  vec_t vecs [6];

  tft_bus_arbiter #(.N_CH(4), .DW(8), .RR(1), .BOOT_CH(0), .BOOT_TO(16)) dut_rr (
    .clk(clk), .rst(rst[0]), .req(req[0]), .ch_data(ch_data[0]), .ch_dc(ch_dc[0]),
    .ch_transmit(ch_transmit[0]), .spi_busy(spi_busy[0]), .spi_data(spi_data[0]),
    .spi_dc(spi_dc[0]), .spi_transmit(spi_transmit[0]), .enable(enable[0]),
    .grant(grant[0]), .boot_done(boot_done[0]), .drop_cnt(drop_cnt[0])
  );

  tft_bus_arbiter #(.N_CH(4), .DW(8), .RR(0), .BOOT_CH(0), .BOOT_TO(1024)) dut_fp (
    .clk(clk), .rst(rst[1]), .req(req[1]), .ch_data(ch_data[1]), .ch_dc(ch_dc[1]),
    .ch_transmit(ch_transmit[1]), .spi_busy(spi_busy[1]), .spi_data(spi_data[1]),
    .spi_dc(spi_dc[1]), .spi_transmit(spi_transmit[1]), .enable(enable[1]),
    .grant(grant[1]), .boot_done(boot_done[1]), .drop_cnt(drop_cnt[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input logic [3:0] g);
    case (g)
      4'b0001: exp_byte = 8'h11;
      4'b0010: exp_byte = 8'h22;
      4'b0100: exp_byte = 8'h33;
      4'b1000: exp_byte = 8'h44;
      default: exp_byte = 8'h00;
    endcase
  endfunction

  // Clients hold req=1110; each owner drops its req after 5 owned cycles and re-raises once released.
  task automatic run_rr(input int d);
    logic [3:0] prev;
    int own;
    prev = grant[d];
    own  = 0;
    req[d] = 4'b1110;
    for (int budget = 0; budget < 200 && exp_q.size() > 0; budget++) begin
      tick();
      if (grant[d] != prev) begin
        if (grant[d] != 4'b0000) begin
          check("rr_gap", {28'd0, prev}, 32'd0);
          check("rr_grant", {28'd0, grant[d]}, {28'd0, exp_q.pop_front()});
          check("rr_data", {24'd0, spi_data[d]}, {24'd0, exp_byte(grant[d])});
          check("rr_dc", {31'd0, spi_dc[d]}, {31'd0, |(grant[d] & 4'b1010)});
          $display("inst %0d grant %b data %h", d, grant[d], spi_data[d]);
          own = 1;
        end else begin
          req[d] = 4'b1110;
        end
      end else if (grant[d] != 4'b0000) begin
        own++;
      end
      if (own == 5 && grant[d] != 4'b0000) req[d] = 4'b1110 & ~grant[d];
      prev = grant[d];
    end
    if (exp_q.size() != 0) begin
      check("rr_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{tx: 4'b0000, exp_st: 1'b0, exp_drop: 8'd0};
    vecs[1] = '{tx: 4'b0100, exp_st: 1'b0, exp_drop: 8'd1};
    vecs[2] = '{tx: 4'b0010, exp_st: 1'b1, exp_drop: 8'd1};
    vecs[3] = '{tx: 4'b0100, exp_st: 1'b0, exp_drop: 8'd2};
    vecs[4] = '{tx: 4'b0110, exp_st: 1'b1, exp_drop: 8'd3};
    vecs[5] = '{tx: 4'b0000, exp_st: 1'b0, exp_drop: 8'd3};

    for (int d = 0; d < 2; d++) begin
      rst[d]         = 1'b0;
      req[d]         = 4'b0000;
      ch_data[d]     = 32'h44332211;
      ch_dc[d]       = 4'b1010;
      ch_transmit[d] = 4'b0000;
      spi_busy[d]    = 1'b0;
    end
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_grant", {28'd0, grant[d]}, 32'd0);
      check("rst_enable", {28'd0, enable[d]}, 32'h1);
      check("rst_boot_done", {31'd0, boot_done[d]}, 32'd0);
      check("rst_drop", {24'd0, drop_cnt[d]}, 32'd0);
      check("rst_tx", {31'd0, spi_transmit[d]}, 32'd0);
    end
    rst[0] = 1'b1;
    rst[1] = 1'b1;

    // Boot timeout on the BOOT_TO=16 instance: boot_done rises at the 16th edge.
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("boot_to_done", {31'd0, boot_done[0]}, (k == 16) ? 32'd1 : 32'd0);
    end
    check("boot_to_enable", {28'd0, enable[0]}, 32'hE);
    check("boot_to_grant", {28'd0, grant[0]}, 32'd0);

    // Boot run on the fixed-priority instance: req[0] high for 20 cycles.
    req[1] = 4'b0001;
    #1;
    check("boot_pre_grant", {28'd0, grant[1]}, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("boot_grant", {28'd0, grant[1]}, 32'h1);
      check("boot_done_low", {31'd0, boot_done[1]}, 32'd0);
    end
    check("boot_data", {24'd0, spi_data[1]}, 32'h11);
    req[1] = 4'b0000;
    tick();
    check("boot_end_done", {31'd0, boot_done[1]}, 32'd1);
    check("boot_end_enable", {28'd0, enable[1]}, 32'hE);
    check("boot_end_grant", {28'd0, grant[1]}, 32'd0);

    // Round-robin rotation.
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0010);
    run_rr(0);

    // Channel 1 owns: strobes from other channels are dropped and counted.
    req[0] = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      ch_transmit[0] = vecs[i].tx;
      #1;
      check("vec_tx", {31'd0, spi_transmit[0]}, {31'd0, vecs[i].exp_st});
      check("vec_data", {24'd0, spi_data[0]}, 32'h22);
      drop_q.push_back(vecs[i].exp_drop);
      tick();
      check("vec_drop", {24'd0, drop_cnt[0]}, {24'd0, drop_q.pop_front()});
    end
    ch_transmit[0] = 4'b0000;

    // Owner drops req while tft_spi is still busy for 4 cycles.
    req[0]      = 4'b0000;
    spi_busy[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("busy_hold", {28'd0, grant[0]}, 32'h2);
    end
    spi_busy[0] = 1'b0;
    tick();
    check("busy_release", {28'd0, grant[0]}, 32'd0);
    check("busy_drop", {24'd0, drop_cnt[0]}, 32'd3);
    check("busy_enable", {28'd0, enable[0]}, 32'hE);

    // Fixed priority starves channels 2 and 3.
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0010);
    run_rr(1);

    // Reset lands mid-transaction on the fixed-priority instance.
    req[1]         = 4'b0010;
    ch_transmit[1] = 4'b1000;
    tick();
    check("fp_drop", {24'd0, drop_cnt[1]}, 32'd1);
    ch_transmit[1] = 4'b0010;
    #1;
    check("fp_tx_owned", {31'd0, spi_transmit[1]}, 32'd1);
    rst[1] = 1'b0;
    tick();
    check("mid_rst_grant", {28'd0, grant[1]}, 32'd0);
    check("mid_rst_enable", {28'd0, enable[1]}, 32'h1);
    check("mid_rst_tx", {31'd0, spi_transmit[1]}, 32'd0);
    check("mid_rst_drop", {24'd0, drop_cnt[1]}, 32'd0);
    check("mid_rst_boot_done", {31'd0, boot_done[1]}, 32'd0);
    tick();
    check("mid_rst_tx_hold", {31'd0, spi_transmit[1]}, 32'd0);
    rst[1] = 1'b1;
    ch_transmit[1] = 4'b0000;
    req[1] = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
